// File: rtl/pattern_source_if.sv
// Control/data bundle for pattern_source: burst request fields in, registered word stream out.
interface pattern_source_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] seed;
    logic [LEN_W-1:0] length;
    logic             hold;
    logic [WIDTH-1:0] out;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, seed, length, hold,
        input  out, valid, busy, done
    );

    modport slave (
        input  start, mode, seed, length, hold,
        output out, valid, busy, done
    );
endinterface

// File: rtl/pattern_source.sv
// Burst generator emitting ramp / LFSR / walking-one words, one per clock.
// Define PATTERN_SOURCE_LFSR_EN to build the LFSR; otherwise mode 2 behaves as an up-ramp.
module pattern_source #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input logic              clk,
    input logic              rst,
    pattern_source_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] CONE = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] out_q,   out_d;
    logic             valid_q, valid_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [LEN_W-1:0] cnt_q,   cnt_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic [1:0]       mode_q,  mode_d;

    function automatic logic [WIDTH-1:0] next_word(input logic [1:0] m, input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        case (m)
            2'd1:    r = w - ONE;
`ifdef PATTERN_SOURCE_LFSR_EN
            2'd2:    r = {w[WIDTH-2:0], w[7] ^ w[5] ^ w[4] ^ w[3]};
`endif
            2'd3:    r = {w[WIDTH-2:0], w[WIDTH-1]};
            default: r = w + ONE;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] first_word(input logic [1:0] m, input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        r = s;
        if (m == 2'd3) r = ONE;
`ifdef PATTERN_SOURCE_LFSR_EN
        // An all-zero LFSR state would lock up, so seed 0 is promoted to 1.
        if (m == 2'd2 && s == '0) r = ONE;
`endif
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        len_d   = len_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    mode_d = bus.mode;
                    len_d  = bus.length;
                    if (bus.length != '0) begin
                        state_d = RUN;
                        out_d   = first_word(bus.mode, bus.seed);
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        cnt_d   = CONE;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN, PAUSE: begin
                // Final count takes priority over hold; PAUSE resumes with the RUN rules.
                if (cnt_q == len_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (bus.hold) begin
                    state_d = PAUSE;
                    busy_d  = 1'b1;
                end else begin
                    state_d = RUN;
                    out_d   = next_word(mode_q, out_q);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = cnt_q + CONE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule
